// File: rtl/picorv32_mem_arbiter_pkg.sv
// Shared definitions for the PicoRV32 native memory port arbiter.
// Holds the FSM state type, the arbitration mode codes and a width helper.
package picorv32_mem_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(n)) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/picorv32_mem_arbiter_if.sv
// Bundle of the upstream per-master native ports, the shared downstream port and grant status.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface picorv32_mem_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned IDX_W       = 3
);
   logic [NUM_MASTERS-1:0]    m_mem_valid;
   logic [NUM_MASTERS-1:0]    m_mem_instr;
   logic [32*NUM_MASTERS-1:0] m_mem_addr;
   logic [32*NUM_MASTERS-1:0] m_mem_wdata;
   logic [4*NUM_MASTERS-1:0]  m_mem_wstrb;
   logic [NUM_MASTERS-1:0]    m_mem_ready;
   logic [32*NUM_MASTERS-1:0] m_mem_rdata;

   logic                      mem_valid;
   logic                      mem_instr;
   logic [31:0]               mem_addr;
   logic [31:0]               mem_wdata;
   logic [3:0]                mem_wstrb;
   logic                      mem_ready;
   logic [31:0]               mem_rdata;

   logic                      grant_valid;
   logic [IDX_W-1:0]          grant_idx;

   modport slave (
      input  m_mem_valid, m_mem_instr, m_mem_addr, m_mem_wdata, m_mem_wstrb,
      output m_mem_ready, m_mem_rdata,
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata,
      output grant_valid, grant_idx
   );

   modport master (
      output m_mem_valid, m_mem_instr, m_mem_addr, m_mem_wdata, m_mem_wstrb,
      input  m_mem_ready, m_mem_rdata,
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata,
      input  grant_valid, grant_idx
   );

endinterface

// File: rtl/picorv32_mem_arbiter_rr_select.sv
// Combinational winner search: round-robin from ptr_i upward with wrap, or lowest index.
module picorv32_rr_select #(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned IDX_W       = 3
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]       ptr_i,
   input  logic                   mode_i,
   output logic                   any_o,
   output logic [IDX_W-1:0]       idx_o
);

   // First pass covers indices at/above the pointer; the second pass supplies the wrap-around.
   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (!any_o && req_i[i] && (mode_i || (IDX_W'(i) >= ptr_i))) begin
            any_o = 1'b1;
            idx_o = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (!any_o && req_i[i]) begin
            any_o = 1'b1;
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one native PicoRV32 memory port among NUM_MASTERS requesters.
// The winner's request is latched at grant and held until the downstream mem_ready.
module picorv32_mem_arbiter
   import picorv32_mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned ARB_MODE    = 0,
   parameter int unsigned IDX_W       = 3
) (
   input  logic                 clk,
   input  logic                 resetn,
   picorv32_mem_arbiter_if.slave bus
);

   localparam logic MODE_FIXED = (ARB_MODE == ARB_FIXED);

   if (IDX_W < clog2(NUM_MASTERS)) begin : g_idx_w_check
      $error("IDX_W too narrow for NUM_MASTERS");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic             grant_valid_q, grant_valid_d;
   logic             mem_valid_q, mem_valid_d;
   logic             mem_instr_q, mem_instr_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [3:0]       mem_wstrb_q, mem_wstrb_d;
   logic             win_any;
   logic [IDX_W-1:0] win_idx;
   logic [NUM_MASTERS-1:0] ready_vec;

   picorv32_rr_select #(
      .NUM_MASTERS(NUM_MASTERS),
      .IDX_W      (IDX_W)
   ) u_sel (
      .req_i (bus.m_mem_valid),
      .ptr_i (rr_ptr_q),
      .mode_i(MODE_FIXED),
      .any_o (win_any),
      .idx_o (win_idx)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         mem_valid_q   <= 1'b0;
         mem_instr_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_wstrb_q   <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         mem_valid_q   <= mem_valid_d;
         mem_instr_q   <= mem_instr_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_wstrb_q   <= mem_wstrb_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      mem_valid_d   = mem_valid_q;
      mem_instr_d   = mem_instr_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_wstrb_d   = mem_wstrb_q;
      case (state_q)
         ST_IDLE: begin
            mem_valid_d = 1'b0;
            if (win_any) begin
               for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                  if (win_idx == IDX_W'(i)) begin
                     mem_instr_d = bus.m_mem_instr[i];
                     mem_addr_d  = bus.m_mem_addr[32*i +: 32];
                     mem_wdata_d = bus.m_mem_wdata[32*i +: 32];
                     mem_wstrb_d = bus.m_mem_wstrb[4*i +: 4];
                  end
               end
               mem_valid_d   = 1'b1;
               grant_idx_d   = win_idx;
               grant_valid_d = 1'b1;
               state_d       = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus.mem_ready) begin
               mem_valid_d   = 1'b0;
               grant_valid_d = 1'b0;
               state_d       = ST_IDLE;
               if (!MODE_FIXED) begin
                  rr_ptr_d = (grant_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                       : grant_idx_q + IDX_W'(1);
               end
            end
         end
      endcase
   end

   always_comb begin
      ready_vec = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if ((state_q == ST_BUSY) && (grant_idx_q == IDX_W'(i))) ready_vec[i] = bus.mem_ready;
      end
   end

   assign bus.m_mem_ready = ready_vec;
   assign bus.m_mem_rdata = {NUM_MASTERS{bus.mem_rdata}};
   assign bus.mem_valid   = mem_valid_q;
   assign bus.mem_instr   = mem_instr_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_wstrb   = mem_wstrb_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Self-checking bench: a round-robin instance with 3 masters and a fixed-priority instance with 2.
// Cycle table, directed corner sequences and a randomized run against a transaction-level model.
module tb_picorv32_mem_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned NF = 2;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   picorv32_mem_arbiter_if #(.NUM_MASTERS(NR), .IDX_W(3)) bus_rr ();
   picorv32_mem_arbiter_if #(.NUM_MASTERS(NF), .IDX_W(3)) bus_fx ();

   picorv32_mem_arbiter #(.NUM_MASTERS(NR), .ARB_MODE(0), .IDX_W(3)) dut_rr (
      .clk(clk), .resetn(resetn), .bus(bus_rr));
   picorv32_mem_arbiter #(.NUM_MASTERS(NF), .ARB_MODE(1), .IDX_W(3)) dut_fx (
      .clk(clk), .resetn(resetn), .bus(bus_fx));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] valid;
      logic       rdy;
      logic       mv;
      logic       gv;
      logic [2:0] gi;
      logic [2:0] mr;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus_rr.m_mem_valid = '0;
      bus_rr.m_mem_instr = '0;
      bus_rr.m_mem_addr  = '0;
      bus_rr.m_mem_wdata = '0;
      bus_rr.m_mem_wstrb = '0;
      bus_rr.mem_ready   = 1'b0;
      bus_rr.mem_rdata   = '0;
      bus_fx.m_mem_valid = '0;
      bus_fx.m_mem_instr = '0;
      bus_fx.m_mem_addr  = '0;
      bus_fx.m_mem_wdata = '0;
      bus_fx.m_mem_wstrb = '0;
      bus_fx.mem_ready   = 1'b0;
      bus_fx.mem_rdata   = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   // Transaction-level model state for the randomized run
   logic [NR-1:0] pend;
   logic [31:0]   raddr [NR];
   logic [31:0]   rwdata[NR];
   logic [3:0]    rwstrb[NR];
   logic          rinstr[NR];
   int            gcount[NR];

   initial begin
      int mptr, mwin, wleft;
      bit mbusy;

      tbl[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000};
      tbl[1]  = '{3'b011, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000};
      tbl[2]  = '{3'b011, 1'b0, 1'b1, 1'b1, 3'd0, 3'b000};
      tbl[3]  = '{3'b011, 1'b1, 1'b1, 1'b1, 3'd0, 3'b001};
      tbl[4]  = '{3'b010, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000};
      tbl[5]  = '{3'b010, 1'b1, 1'b1, 1'b1, 3'd1, 3'b010};
      tbl[6]  = '{3'b101, 1'b0, 1'b0, 1'b0, 3'd1, 3'b000};
      tbl[7]  = '{3'b101, 1'b1, 1'b1, 1'b1, 3'd2, 3'b100};
      tbl[8]  = '{3'b101, 1'b0, 1'b0, 1'b0, 3'd2, 3'b000};
      tbl[9]  = '{3'b100, 1'b0, 1'b1, 1'b1, 3'd0, 3'b000};
      tbl[10] = '{3'b100, 1'b1, 1'b1, 1'b1, 3'd0, 3'b001};
      tbl[11] = '{3'b100, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000};
      tbl[12] = '{3'b000, 1'b1, 1'b1, 1'b1, 3'd2, 3'b100};
      tbl[13] = '{3'b000, 1'b1, 1'b0, 1'b0, 3'd2, 3'b000};
      tbl[14] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'd2, 3'b000};

      // Reset state, with mem_ready high to show ready stays low while idle
      do_reset();
      bus_rr.mem_ready = 1'b1;
      #1;
      chk("rst_mem_valid", bus_rr.mem_valid, 0);
      chk("rst_mem_instr", bus_rr.mem_instr, 0);
      chk("rst_mem_addr", bus_rr.mem_addr, 0);
      chk("rst_mem_wdata", bus_rr.mem_wdata, 0);
      chk("rst_mem_wstrb", bus_rr.mem_wstrb, 0);
      chk("rst_grant_valid", bus_rr.grant_valid, 0);
      chk("rst_grant_idx", bus_rr.grant_idx, 0);
      chk("rst_m_mem_ready", bus_rr.m_mem_ready, 0);

      // Cycle table
      do_reset();
      bus_rr.m_mem_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
      for (int k = 0; k < 15; k++) begin
         bus_rr.m_mem_valid = tbl[k].valid;
         bus_rr.mem_ready   = tbl[k].rdy;
         #1;
         chk($sformatf("tbl%0d_mem_valid", k), bus_rr.mem_valid, tbl[k].mv);
         chk($sformatf("tbl%0d_grant_valid", k), bus_rr.grant_valid, tbl[k].gv);
         chk($sformatf("tbl%0d_grant_idx", k), bus_rr.grant_idx, tbl[k].gi);
         chk($sformatf("tbl%0d_m_mem_ready", k), bus_rr.m_mem_ready, tbl[k].mr);
         if (tbl[k].mv)
            chk($sformatf("tbl%0d_mem_addr", k), bus_rr.mem_addr, 32'h1000 * (tbl[k].gi + 1));
         tick();
      end

      // Single read by master 0 with two wait cycles
      do_reset();
      bus_rr.m_mem_addr[31:0] = 32'h0000_0100;
      bus_rr.m_mem_instr[0]   = 1'b1;
      bus_rr.m_mem_valid      = 3'b001;
      #1;
      chk("rd_no_valid_yet", bus_rr.mem_valid, 0);
      tick();
      chk("rd_mem_valid", bus_rr.mem_valid, 1);
      chk("rd_mem_addr", bus_rr.mem_addr, 32'h100);
      chk("rd_mem_wstrb", bus_rr.mem_wstrb, 0);
      chk("rd_mem_instr", bus_rr.mem_instr, 1);
      chk("rd_wait_ready", bus_rr.m_mem_ready, 0);
      tick();
      chk("rd_wait2_valid", bus_rr.mem_valid, 1);
      tick();
      bus_rr.mem_ready = 1'b1;
      bus_rr.mem_rdata = 32'h1234_5678;
      #1;
      chk("rd_m_ready", bus_rr.m_mem_ready, 3'b001);
      chk("rd_rdata", bus_rr.m_mem_rdata[31:0], 32'h1234_5678);
      tick();
      bus_rr.mem_ready   = 1'b0;
      bus_rr.m_mem_valid = 3'b000;
      chk("rd_bubble", bus_rr.mem_valid, 0);
      chk("rd_gv_drop", bus_rr.grant_valid, 0);

      // Master 1 write, with its request fields changing mid-transaction
      bus_rr.m_mem_addr[63:32]  = 32'h0000_0200;
      bus_rr.m_mem_wdata[63:32] = 32'hCAFE_F00D;
      bus_rr.m_mem_wstrb[7:4]   = 4'b0011;
      bus_rr.m_mem_instr[1]     = 1'b0;
      bus_rr.m_mem_valid        = 3'b010;
      tick();
      chk("wr_grant_idx", bus_rr.grant_idx, 1);
      bus_rr.m_mem_addr[63:32]  = 32'hDEAD_0000;
      bus_rr.m_mem_wdata[63:32] = 32'h0BAD_BEEF;
      bus_rr.m_mem_wstrb[7:4]   = 4'b1111;
      for (int w = 0; w < 2; w++) begin
         tick();
         chk("wr_hold_addr", bus_rr.mem_addr, 32'h200);
         chk("wr_hold_wdata", bus_rr.mem_wdata, 32'hCAFE_F00D);
         chk("wr_hold_wstrb", bus_rr.mem_wstrb, 4'b0011);
      end
      bus_rr.mem_ready = 1'b1;
      #1;
      chk("wr_m_ready", bus_rr.m_mem_ready, 3'b010);
      tick();
      bus_rr.mem_ready   = 1'b0;
      bus_rr.m_mem_valid = 3'b001;
      tick();
      bus_rr.mem_ready = 1'b1;
      tick();
      bus_rr.mem_ready   = 1'b0;
      bus_rr.m_mem_valid = 3'b100;

      // Reset in the middle of a transaction: pointer must return to 0
      tick();
      chk("rb_busy", bus_rr.grant_idx, 2);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("rb_mem_valid", bus_rr.mem_valid, 0);
      chk("rb_grant_valid", bus_rr.grant_valid, 0);
      bus_rr.m_mem_valid = 3'b011;
      tick();
      chk("rb_first_grant", bus_rr.grant_idx, 0);
      bus_rr.mem_ready = 1'b1;
      tick();
      bus_rr.mem_ready   = 1'b0;
      bus_rr.m_mem_valid = 3'b010;
      tick();
      chk("rb_second_grant", bus_rr.grant_idx, 1);
      chk("rb_second_valid", bus_rr.mem_valid, 1);

      // Fairness: all masters requesting, zero-wait memory
      do_reset();
      bus_rr.m_mem_valid = 3'b111;
      tick();
      for (int t = 0; t < 9; t++) begin
         chk($sformatf("fair%0d_valid", t), bus_rr.mem_valid, 1);
         chk($sformatf("fair%0d_idx", t), bus_rr.grant_idx, t % 3);
         bus_rr.mem_ready = 1'b1;
         #1;
         chk($sformatf("fair%0d_ready", t), bus_rr.m_mem_ready, 3'b001 << (t % 3));
         tick();
         bus_rr.mem_ready = 1'b0;
         chk($sformatf("fair%0d_bubble", t), bus_rr.mem_valid, 0);
         tick();
      end

      // Fixed priority: master 0 always wins until it stops requesting
      do_reset();
      bus_fx.m_mem_valid = 2'b11;
      tick();
      for (int t = 0; t < 4; t++) begin
         chk($sformatf("fx%0d_idx", t), bus_fx.grant_idx, 0);
         chk($sformatf("fx%0d_valid", t), bus_fx.mem_valid, 1);
         bus_fx.mem_ready = 1'b1;
         tick();
         bus_fx.mem_ready = 1'b0;
         if (t == 3) bus_fx.m_mem_valid = 2'b10;
         tick();
      end
      chk("fx_m1_idx", bus_fx.grant_idx, 1);
      chk("fx_m1_valid", bus_fx.mem_valid, 1);
      bus_fx.mem_ready = 1'b1;
      #1;
      chk("fx_m1_ready", bus_fx.m_mem_ready, 2'b10);
      tick();
      idle_inputs();

      // Randomized traffic against a transaction-level model
      do_reset();
      pend  = '0;
      mptr  = 0;
      mbusy = 0;
      mwin  = 0;
      wleft = 0;
      for (int i = 0; i < NR; i++) gcount[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]   = 1'b1;
               raddr[i]  = $urandom;
               rwdata[i] = $urandom;
               rwstrb[i] = 4'($urandom);
               rinstr[i] = 1'($urandom);
            end
            bus_rr.m_mem_addr[32*i +: 32]  = raddr[i];
            bus_rr.m_mem_wdata[32*i +: 32] = rwdata[i];
            bus_rr.m_mem_wstrb[4*i +: 4]   = rwstrb[i];
            bus_rr.m_mem_instr[i]          = rinstr[i];
         end
         bus_rr.m_mem_valid = pend;
         bus_rr.mem_rdata   = $urandom;
         if (mbusy) begin
            bus_rr.mem_ready = (wleft == 0);
            #1;
            chk("rnd_valid", bus_rr.mem_valid, 1);
            chk("rnd_idx", bus_rr.grant_idx, mwin);
            chk("rnd_addr", bus_rr.mem_addr, raddr[mwin]);
            chk("rnd_wdata", bus_rr.mem_wdata, rwdata[mwin]);
            chk("rnd_wstrb", bus_rr.mem_wstrb, rwstrb[mwin]);
            chk("rnd_instr", bus_rr.mem_instr, rinstr[mwin]);
            chk("rnd_ready", bus_rr.m_mem_ready, (wleft == 0) ? (3'b001 << mwin) : 3'b000);
            if (wleft == 0) begin
               chk("rnd_rdata", bus_rr.m_mem_rdata[32*mwin +: 32], bus_rr.mem_rdata);
               pend[mwin] = 1'b0;
               gcount[mwin]++;
               mptr  = (mwin + 1) % NR;
               mbusy = 0;
            end else begin
               wleft--;
            end
         end else begin
            bus_rr.mem_ready = ($urandom_range(0, 3) == 0);
            #1;
            chk("rnd_idle_valid", bus_rr.mem_valid, 0);
            chk("rnd_idle_ready", bus_rr.m_mem_ready, 0);
            if (pend != '0) begin
               for (int k = 0; k < NR; k++) begin
                  if (!mbusy && pend[(mptr + k) % NR]) begin
                     mwin  = (mptr + k) % NR;
                     mbusy = 1;
                  end
               end
               wleft = $urandom_range(0, 2);
            end
         end
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < NR; i++) chk($sformatf("rnd_served%0d", i), gcount[i] > 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
